// File: rtl/holysoc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : holysoc_pkg
// Purpose  : Shared encodings for the HolySoC front end: PC next-address
//            select codes and the pc_gen state enumeration.
// Revision : 1.0 - initial release
// ============================================================================
package holysoc_pkg;

   // Next-address select encodings presented on addr_sel
   localparam logic [1:0] PCSEL_PLUS4  = 2'b00;
   localparam logic [1:0] PCSEL_BRANCH = 2'b01;
   localparam logic [1:0] PCSEL_JALR   = 2'b10;
   localparam logic [1:0] PCSEL_TRAP   = 2'b11;

   // pc_gen control states
   typedef enum logic [1:0] {
      S_RESET = 2'b00,
      S_RUN   = 2'b01,
      S_HALT  = 2'b10
   } pcgen_state_t;

endpackage : holysoc_pkg
`default_nettype wire

// File: rtl/pc_next_sel.sv
`default_nettype none
// ============================================================================
// Module   : pc_next_sel
// Purpose  : Combinational next-PC selector with target alignment check.
//            A misaligned branch/JALR target is replaced by the trap vector.
// Revision : 1.0 - initial release
// ============================================================================
module pc_next_sel
   import holysoc_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int IALIGN = 4
) (
   input  logic [1:0]      addr_sel_i,
   input  logic [XLEN-1:0] pc_plus4_i,
   input  logic [XLEN-1:0] branch_target_i,
   input  logic [XLEN-1:0] alu_result_i,
   input  logic [XLEN-1:0] trap_vector_i,
   output logic [XLEN-1:0] next_o,
   output logic [XLEN-1:0] target_o,
   output logic            misalign_hit_o
);

   logic [XLEN-1:0] w_trap_base;
   logic [XLEN-1:0] w_jalr_target;
   logic [XLEN-1:0] w_target;
   logic            w_bad_align;

   // Trap base is always word aligned; JALR drops bit 0 of the sum
   assign w_trap_base   = trap_vector_i & ~XLEN'(3);
   assign w_jalr_target = alu_result_i  & ~XLEN'(1);
   assign w_target      = (addr_sel_i == PCSEL_JALR) ? w_jalr_target : branch_target_i;
   assign target_o      = w_target;

   // Only the low bit matters for 2-byte alignment; any other value means 4
   generate
      if (IALIGN == 2) begin : g_ialign2
         assign w_bad_align = w_target[0];
      end else begin : g_ialign4
         assign w_bad_align = |w_target[1:0];
      end
   endgenerate

   // Next-address mux; misaligned redirects fall through to the trap base
   always_comb begin
      next_o         = pc_plus4_i;
      misalign_hit_o = 1'b0;
      case (addr_sel_i)
         PCSEL_PLUS4: next_o = pc_plus4_i;
         PCSEL_BRANCH,
         PCSEL_JALR: begin
            misalign_hit_o = w_bad_align;
            next_o         = w_bad_align ? w_trap_base : w_target;
         end
         PCSEL_TRAP:  next_o = w_trap_base;
         default:     next_o = pc_plus4_i;
      endcase
   end

endmodule : pc_next_sel
`default_nettype wire

// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : pc_gen
// Purpose  : Program-counter generator for the HolySoC front end. Holds the
//            PC, advances it under a fetch valid/ready handshake with stall
//            and halt control, and flags misaligned redirect targets.
// Revision : 1.0 - initial release
// ============================================================================
module pc_gen
   import holysoc_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int              IALIGN       = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [1:0]      addr_sel,
   input  logic [XLEN-1:0] branch_target,
   input  logic [XLEN-1:0] alu_result,
   input  logic [XLEN-1:0] trap_vector,
   input  logic            stall,
   input  logic            halt,
   input  logic            resume,
   input  logic            fetch_ready,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus4,
   output logic            fetch_valid,
   output logic            misaligned,
   output logic [XLEN-1:0] misaligned_addr,
   output logic            halted
);

   pcgen_state_t    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            mis_q, mis_d;
   logic [XLEN-1:0] mis_addr_q, mis_addr_d;

   logic [XLEN-1:0] w_next;
   logic [XLEN-1:0] w_target;
   logic            w_hit;

   assign pc_plus4 = pc_q + XLEN'(4);

   pc_next_sel #(
      .XLEN   (XLEN),
      .IALIGN (IALIGN)
   ) u_next_sel (
      .addr_sel_i      (addr_sel),
      .pc_plus4_i      (pc_plus4),
      .branch_target_i (branch_target),
      .alu_result_i    (alu_result),
      .trap_vector_i   (trap_vector),
      .next_o          (w_next),
      .target_o        (w_target),
      .misalign_hit_o  (w_hit)
   );

   // Next-state logic: halt beats stall/backpressure, which beats advance
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      mis_d      = 1'b0;
      mis_addr_d = mis_addr_q;
      case (state_q)
         S_RESET: state_d = S_RUN;
         S_RUN: begin
            if (halt) begin
               state_d = S_HALT;
            end else if (fetch_ready && !stall) begin
               pc_d = w_next;
               if (w_hit) begin
                  mis_d      = 1'b1;
                  mis_addr_d = w_target;
               end
            end
         end
         S_HALT: begin
            if (resume) state_d = S_RUN;
         end
         default: state_d = S_RESET;
      endcase
   end

   // State, PC and misalign registers; reset overrides everything at the edge
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_RESET;
         pc_q       <= RESET_VECTOR;
         mis_q      <= 1'b0;
         mis_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         mis_q      <= mis_d;
         mis_addr_q <= mis_addr_d;
      end
   end

   assign pc              = pc_q;
   assign fetch_valid     = (state_q == S_RUN);
   assign halted          = (state_q == S_HALT);
   assign misaligned      = mis_q;
   assign misaligned_addr = mis_addr_q;

endmodule : pc_gen
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_gen
// Purpose  : Directed self-checking bench for pc_gen (XLEN=32, IALIGN=4,
//            RESET_VECTOR=0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_gen;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  addr_sel;
   logic [31:0] branch_target;
   logic [31:0] alu_result;
   logic [31:0] trap_vector;
   logic        stall;
   logic        halt;
   logic        resume;
   logic        fetch_ready;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        fetch_valid;
   logic        misaligned;
   logic [31:0] misaligned_addr;
   logic        halted;

   int n_vec = 0;
   int n_err = 0;

   pc_gen #(
      .XLEN         (32),
      .RESET_VECTOR (32'h0000_0000),
      .IALIGN       (4)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .addr_sel        (addr_sel),
      .branch_target   (branch_target),
      .alu_result      (alu_result),
      .trap_vector     (trap_vector),
      .stall           (stall),
      .halt            (halt),
      .resume          (resume),
      .fetch_ready     (fetch_ready),
      .pc              (pc),
      .pc_plus4        (pc_plus4),
      .fetch_valid     (fetch_valid),
      .misaligned      (misaligned),
      .misaligned_addr (misaligned_addr),
      .halted          (halted)
   );

   always #5 clk = ~clk;

   // Advance one edge and settle just after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; addr_sel = 2'b00; branch_target = '0; alu_result = '0;
      trap_vector = '0; stall = 1'b0; halt = 1'b0; resume = 1'b0; fetch_ready = 1'b0;
      repeat (3) tick();
      n_vec++;
      if (pc !== 32'h0 || fetch_valid !== 1'b0 || halted !== 1'b0 ||
          misaligned !== 1'b0 || misaligned_addr !== 32'h0) begin
         n_err++;
         $display("FAIL reset_state: pc=%h fv=%b halted=%b mis=%b maddr=%h required 0/0/0/0/0",
                  pc, fetch_valid, halted, misaligned, misaligned_addr);
      end
      rst_n = 1'b1; fetch_ready = 1'b1;
      #1;
      n_vec++;
      if (fetch_valid !== 1'b0 || pc !== 32'h0) begin
         n_err++;
         $display("FAIL reset_cycle: fv=%b pc=%h required 0 / 00000000", fetch_valid, pc);
      end
      tick();
      n_vec++;
      if (fetch_valid !== 1'b1 || pc !== 32'h0 || pc_plus4 !== 32'h4) begin
         n_err++;
         $display("FAIL first_run: fv=%b pc=%h pc4=%h required 1 / 00000000 / 00000004",
                  fetch_valid, pc, pc_plus4);
      end
   endtask

   task automatic test_sequential();
      logic [31:0] exp_pc [2] = '{32'h4, 32'h8};
      for (int i = 0; i < 2; i++) begin
         tick();
         n_vec++;
         if (pc !== exp_pc[i]) begin
            n_err++;
            $display("FAIL seq_step%0d: pc=%h required %h", i, pc, exp_pc[i]);
         end
      end
   endtask

   task automatic test_branch_jalr();
      addr_sel = 2'b01; branch_target = 32'h100;
      tick();
      branch_target = 32'h200;
      tick();
      n_vec++;
      if (pc !== 32'h200) begin
         n_err++;
         $display("FAIL branch: pc=%h required 00000200", pc);
      end
      addr_sel = 2'b10; alu_result = 32'h305;
      tick();
      n_vec++;
      if (pc !== 32'h304 || misaligned !== 1'b0) begin
         n_err++;
         $display("FAIL jalr: pc=%h mis=%b required 00000304 / 0", pc, misaligned);
      end
      addr_sel = 2'b11; trap_vector = 32'h8000_0003;
      tick();
      n_vec++;
      if (pc !== 32'h8000_0000 || misaligned !== 1'b0) begin
         n_err++;
         $display("FAIL trap_sel: pc=%h mis=%b required 80000000 / 0", pc, misaligned);
      end
   endtask

   task automatic test_misaligned();
      addr_sel = 2'b01; branch_target = 32'h202; trap_vector = 32'h8000_0003;
      tick();
      n_vec++;
      if (pc !== 32'h8000_0000 || misaligned !== 1'b1 || misaligned_addr !== 32'h202) begin
         n_err++;
         $display("FAIL mis_branch: pc=%h mis=%b maddr=%h required 80000000 / 1 / 00000202",
                  pc, misaligned, misaligned_addr);
      end
      addr_sel = 2'b00;
      tick();
      n_vec++;
      if (pc !== 32'h8000_0004 || misaligned !== 1'b0 || misaligned_addr !== 32'h202) begin
         n_err++;
         $display("FAIL mis_pulse_end: pc=%h mis=%b maddr=%h required 80000004 / 0 / 00000202",
                  pc, misaligned, misaligned_addr);
      end
      addr_sel = 2'b10; alu_result = 32'h307; trap_vector = 32'h0000_1000;
      tick();
      n_vec++;
      if (pc !== 32'h1000 || misaligned !== 1'b1 || misaligned_addr !== 32'h306) begin
         n_err++;
         $display("FAIL mis_jalr: pc=%h mis=%b maddr=%h required 00001000 / 1 / 00000306",
                  pc, misaligned, misaligned_addr);
      end
   endtask

   task automatic test_stall();
      logic [31:0] held;
      held = pc;
      addr_sel = 2'b01; branch_target = 32'h400;
      for (int i = 0; i < 4; i++) begin
         stall       = (i < 2);
         fetch_ready = (i >= 2) ? 1'b0 : 1'b1;
         tick();
         n_vec++;
         if (pc !== held || fetch_valid !== 1'b1 || misaligned !== 1'b0) begin
            n_err++;
            $display("FAIL stall%0d: pc=%h fv=%b mis=%b required %h / 1 / 0",
                     i, pc, fetch_valid, misaligned, held);
         end
      end
      stall = 1'b0; fetch_ready = 1'b1;
      tick();
      n_vec++;
      if (pc !== 32'h400) begin
         n_err++;
         $display("FAIL stall_release: pc=%h required 00000400", pc);
      end
   endtask

   task automatic test_halt_resume();
      addr_sel = 2'b01; branch_target = 32'h10;
      tick();
      addr_sel = 2'b00; halt = 1'b1;
      tick();
      halt = 1'b0;
      n_vec++;
      if (halted !== 1'b1 || fetch_valid !== 1'b0 || pc !== 32'h10) begin
         n_err++;
         $display("FAIL halt: halted=%b fv=%b pc=%h required 1 / 0 / 00000010",
                  halted, fetch_valid, pc);
      end
      tick();
      n_vec++;
      if (halted !== 1'b1 || pc !== 32'h10) begin
         n_err++;
         $display("FAIL halt_hold: halted=%b pc=%h required 1 / 00000010", halted, pc);
      end
      resume = 1'b1;
      tick();
      resume = 1'b0;
      n_vec++;
      if (halted !== 1'b0 || fetch_valid !== 1'b1 || pc !== 32'h10) begin
         n_err++;
         $display("FAIL resume: halted=%b fv=%b pc=%h required 0 / 1 / 00000010",
                  halted, fetch_valid, pc);
      end
      tick();
      n_vec++;
      if (pc !== 32'h14) begin
         n_err++;
         $display("FAIL resume_step: pc=%h required 00000014", pc);
      end
      halt = 1'b1; resume = 1'b1;
      tick();
      halt = 1'b0; resume = 1'b0;
      n_vec++;
      if (halted !== 1'b1 || pc !== 32'h14) begin
         n_err++;
         $display("FAIL halt_beats_resume: halted=%b pc=%h required 1 / 00000014", halted, pc);
      end
   endtask

   task automatic test_reset_mid_halt();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      n_vec++;
      if (pc !== 32'h0 || halted !== 1'b0 || misaligned !== 1'b0 || fetch_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_mid_halt: pc=%h halted=%b mis=%b fv=%b required 00000000 / 0 / 0 / 0",
                  pc, halted, misaligned, fetch_valid);
      end
      tick();
   endtask

   task automatic test_wrap();
      addr_sel = 2'b01; branch_target = 32'hFFFF_FFFC;
      tick();
      n_vec++;
      if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin
         n_err++;
         $display("FAIL wrap_pc4: pc=%h pc4=%h required fffffffc / 00000000", pc, pc_plus4);
      end
      addr_sel = 2'b00;
      tick();
      n_vec++;
      if (pc !== 32'h0 || misaligned !== 1'b0) begin
         n_err++;
         $display("FAIL wrap: pc=%h mis=%b required 00000000 / 0", pc, misaligned);
      end
   endtask

   task automatic test_reset_clears_pulse();
      addr_sel = 2'b01; branch_target = 32'h202; rst_n = 1'b0;
      tick();
      rst_n = 1'b1; addr_sel = 2'b00;
      n_vec++;
      if (misaligned !== 1'b0 || misaligned_addr !== 32'h0 || pc !== 32'h0) begin
         n_err++;
         $display("FAIL reset_vs_mis: mis=%b maddr=%h pc=%h required 0 / 00000000 / 00000000",
                  misaligned, misaligned_addr, pc);
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_branch_jalr();
      test_misaligned();
      test_stall();
      test_halt_resume();
      test_reset_mid_halt();
      test_wrap();
      test_reset_clears_pulse();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_pc_gen
`default_nettype wire
